// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 frame receiver: FSM states, frame layout, parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLow,
        StHigh,
        StCheck,
        StFault
    } ps2_state_e;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned START_IDX  = 0;
    localparam int unsigned PARITY_IDX = 9;
    localparam int unsigned STOP_IDX   = 10;

    // True when the data byte plus its parity bit hold an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// PS/2 line inputs and scan-code outputs of the frame receiver.
interface ps2_frame_receiver_if;

    logic       ps2Clk;
    logic       ps2Data;
    logic [7:0] data;
    logic       dataReady;
    logic       error;

    // Receiver side: consumes the raw lines, produces scan codes.
    modport master (
        input  ps2Clk,
        input  ps2Data,
        output data,
        output dataReady,
        output error
    );

    // Bus/decoder side: drives the raw lines, observes scan codes.
    modport slave (
        output ps2Clk,
        output ps2Data,
        input  data,
        input  dataReady,
        input  error
    );

endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer followed by a run-length glitch filter with registered edge strobes.
// With filterLen=1 it degenerates to synchronizer plus one register stage.
module ps2_line_filter #(
    parameter int unsigned filterLen = 3
) (
    input  logic clk,
    input  logic resetN,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntBits = (filterLen > 1) ? $clog2(filterLen) : 1;
    localparam logic [CntBits-1:0] CntLast = CntBits'(filterLen - 1);

    logic [1:0]         sync_q;
    logic               level_q, level_d;
    logic [CntBits-1:0] cnt_q, cnt_d;
    logic               rise_q, fall_q;

    // Synchronizer, filtered level and edge strobes; idle bus level is high.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], line};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= ~level_q & level_d;
            fall_q  <= level_q & ~level_d;
        end
    end

    // Accept a new level only after filterLen consecutive differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: conditions the raw lines, times each clock phase, assembles the
// 11-bit frame and publishes validated scan codes with a one-cycle dataReady pulse.
// readAt must be smaller than minClk so the sample point always lies inside a legal low phase.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned counterBits = 8,
    parameter int unsigned minClk      = 15,
    parameter int unsigned maxClk      = 25,
    parameter int unsigned readAt      = 5,
    parameter int unsigned filterLen   = 3
) (
    input  logic                 clk,
    input  logic                 resetN,
    ps2_frame_receiver_if.master bus
);

    localparam logic [counterBits-1:0] MinT     = counterBits'(minClk);
    localparam logic [counterBits-1:0] MaxT     = counterBits'(maxClk);
    localparam logic [counterBits-1:0] SatT     = counterBits'(maxClk + 1);
    localparam logic [counterBits-1:0] ReadT    = counterBits'(readAt);
    localparam logic [counterBits-1:0] IdleLast = counterBits'(maxClk - 1);
    localparam logic [3:0]             StopCnt  = 4'(STOP_IDX);

    logic clk_level, clk_rise, clk_fall;
    logic data_level;
    logic unused_data_rise, unused_data_fall;

    ps2_line_filter #(
        .filterLen(filterLen)
    ) u_clk_filter (
        .clk   (clk),
        .resetN(resetN),
        .line  (bus.ps2Clk),
        .level (clk_level),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    ps2_line_filter #(
        .filterLen(1)
    ) u_data_sync (
        .clk   (clk),
        .resetN(resetN),
        .line  (bus.ps2Data),
        .level (data_level),
        .rise  (unused_data_rise),
        .fall  (unused_data_fall)
    );

    ps2_state_e                 state_q, state_d;
    logic [counterBits-1:0]     timer_q, timer_d;
    logic [3:0]                 count_q, count_d;
    logic [FRAME_BITS-1:0]      bits_q, bits_d;
    logic [7:0]                 data_q, data_d;
    logic                       error_q, error_d;
    logic [counterBits-1:0]     timer_inc;
    logic                       frame_ok;

    // Phase timer saturates one past maxClk so timeouts stay visible without wrapping.
    assign timer_inc = (timer_q >= SatT) ? SatT : timer_q + 1'b1;

    assign frame_ok = (bits_q[START_IDX] == 1'b0) && bits_q[STOP_IDX] &&
                      odd_parity(bits_q[PARITY_IDX-1:START_IDX+1], bits_q[PARITY_IDX]);

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            timer_q <= '0;
            count_q <= '0;
            bits_q  <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            bits_q  <= bits_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    // Next-state and datapath update; timeouts take priority over a coincident edge.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        bits_d  = bits_q;
        data_d  = data_q;
        error_d = error_q;
        case (state_q)
            StIdle: begin
                if (clk_fall) begin
                    state_d = StLow;
                    count_d = '0;
                    timer_d = '0;
                    error_d = 1'b0;
                end
            end
            StLow: begin
                timer_d = timer_inc;
                if (timer_q == ReadT) begin
                    bits_d[count_q] = data_level;
                end
                if (timer_q > MaxT) begin
                    state_d = StFault;
                    timer_d = '0;
                end else if (clk_rise) begin
                    if (timer_q < MinT) begin
                        state_d = StFault;
                        timer_d = '0;
                    end else if (count_q == StopCnt) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StHigh;
                        timer_d = '0;
                    end
                end
            end
            StHigh: begin
                timer_d = timer_inc;
                if (timer_q > MaxT) begin
                    state_d = StFault;
                    timer_d = '0;
                end else if (clk_fall) begin
                    timer_d = '0;
                    if (timer_q < MinT) begin
                        state_d = StFault;
                    end else begin
                        state_d = StLow;
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StCheck: begin
                if (frame_ok) begin
                    data_d  = bits_q[PARITY_IDX-1:START_IDX+1];
                    state_d = StIdle;
                end else begin
                    state_d = StFault;
                    timer_d = '0;
                end
            end
            StFault: begin
                error_d = 1'b1;
                // Timer counts uninterrupted high cycles of the filtered clock.
                if (!clk_level) begin
                    timer_d = '0;
                end else if (timer_q >= IdleLast) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: new code is presented in the CHECK cycle so data and dataReady coincide.
    always_comb begin
        bus.data      = data_q;
        bus.dataReady = 1'b0;
        bus.error     = error_q;
        if ((state_q == StCheck) && frame_ok) begin
            bus.data      = bits_q[PARITY_IDX-1:START_IDX+1];
            bus.dataReady = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Randomized bench for ps2_frame_receiver with a frame-level acceptance model.
module tb_ps2_frame_receiver;

    localparam int FilterLen = 3;
    // 2 synchronizer stages, filterLen samples, then the CHECK cycle.
    localparam int RdyLat    = 2 + FilterLen + 1;

    logic clk;
    logic resetN;

    ps2_frame_receiver_if bus ();

    ps2_frame_receiver #(
        .counterBits(8),
        .minClk     (15),
        .maxClk     (25),
        .readAt     (5),
        .filterLen  (FilterLen)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dataReady monitor: counts pulse cycles and remembers the last one.
    int         rdy_pulses = 0;
    int         rdy_cyc = 0;
    logic [7:0] rdy_data = 8'h00;
    always @(negedge clk) begin
        if (bus.dataReady) begin
            rdy_pulses <= rdy_pulses + 1;
            rdy_cyc    <= cyc;
            rdy_data   <= bus.data;
        end
    end

    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit flip_par,
                                               input bit bad_start, input bit bad_stop);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {~bad_stop, par ^ flip_par, b, bad_start};
    endfunction

    // Acceptance rule: start 0, stop 1, odd ones over data+parity, every phase legal.
    function automatic bit frame_valid(input logic [10:0] fb, input bit short_phase);
        logic [8:0] dp;
        dp = fb[9:1];
        return (fb[0] == 1'b0) && (fb[10] == 1'b1) && ($countones(dp) % 2 == 1) && !short_phase;
    endfunction

    // Drives nbits of a frame; returns right after the last rising edge with the clock high.
    task automatic send_frame(input logic [10:0] fb, input int nbits, input int bad_bit,
                              input int bad_len, input int glitch_bit, output int rise_cyc);
        int lo;
        int hi;
        bus.ps2Data = fb[0];
        idle(8);
        for (int i = 0; i < nbits; i++) begin
            lo = (i == bad_bit) ? bad_len : int'($urandom_range(24, 17));
            bus.ps2Clk = 1'b0;
            idle(lo);
            bus.ps2Clk = 1'b1;
            rise_cyc = cyc;
            if (i == nbits - 1) break;
            hi = int'($urandom_range(24, 17));
            idle(2);
            bus.ps2Data = fb[i+1];
            if (i == glitch_bit) begin
                idle(4);
                bus.ps2Clk = 1'b0;
                idle(2);
                bus.ps2Clk = 1'b1;
                idle(hi - 8);
            end else begin
                idle(hi - 2);
            end
        end
        bus.ps2Data = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit flip_par,
                             input bit bad_start, input bit bad_stop, input int bad_bit,
                             input int bad_len, input int glitch_bit);
        logic [10:0] fb;
        bit          ok;
        int          p0;
        int          rc;
        fb = make_frame(b, flip_par, bad_start, bad_stop);
        ok = frame_valid(fb, bad_bit >= 0);
        p0 = rdy_pulses;
        send_frame(fb, 11, bad_bit, bad_len, glitch_bit, rc);
        idle(12);
        check_eq({tag, "_pulses"}, rdy_pulses - p0, ok ? 1 : 0);
        if (ok) begin
            check_eq({tag, "_latency"}, rdy_cyc - rc, RdyLat);
            check_eq({tag, "_rdydata"}, int'(rdy_data), int'(b));
            last_good = b;
        end
        check_eq({tag, "_data"}, int'(bus.data), int'(last_good));
        check_eq({tag, "_error"}, int'(bus.error), ok ? 0 : 1);
        idle(60);
    endtask

    initial begin
        int          rc;
        int          p0;
        logic [10:0] fb;
        int          kind;
        bus.ps2Clk  = 1'b1;
        bus.ps2Data = 1'b1;
        resetN      = 1'b0;
        idle(3);
        check_eq("rst_data", int'(bus.data), 0);
        check_eq("rst_ready", int'(bus.dataReady), 0);
        check_eq("rst_error", int'(bus.error), 0);
        resetN = 1'b1;
        idle(10);

        run_frame("f1c", 8'h1C, 0, 0, 0, -1, 0, -1);
        run_frame("par", 8'h1C, 1, 0, 0, -1, 0, -1);
        run_frame("ff0", 8'hF0, 0, 0, 0, -1, 0, -1);

        // Mid-frame timeout: five bits, then the clock parks high.
        fb = make_frame(8'h33, 0, 0, 0);
        p0 = rdy_pulses;
        send_frame(fb, 5, -1, 0, -1, rc);
        idle(20);
        check_eq("tmo_early", int'(bus.error), 0);
        idle(20);
        check_eq("tmo_error", int'(bus.error), 1);
        check_eq("tmo_pulses", rdy_pulses - p0, 0);
        check_eq("tmo_data", int'(bus.data), int'(last_good));
        idle(60);
        run_frame("f5a", 8'h5A, 0, 0, 0, -1, 0, -1);

        // Glitch in idle must not start a frame (a false start would time out into error).
        p0 = rdy_pulses;
        bus.ps2Clk = 1'b0;
        idle(2);
        bus.ps2Clk = 1'b1;
        idle(40);
        check_eq("glitch_idle_err", int'(bus.error), 0);
        check_eq("glitch_idle_pulses", rdy_pulses - p0, 0);
        run_frame("f29", 8'h29, 0, 0, 0, -1, 0, 3);

        run_frame("short", 8'h44, 0, 0, 0, 2, 8, -1);

        for (int n = 0; n < 20; n++) begin
            kind = int'($urandom_range(5, 0));
            case (kind)
                3:       run_frame("rnd_par", 8'($urandom_range(255, 0)), 1, 0, 0, -1, 0, -1);
                4:       run_frame("rnd_frm", 8'($urandom_range(255, 0)), 0,
                                   ($urandom_range(1, 0) == 1), ($urandom_range(1, 0) == 0),
                                   -1, 0, -1);
                5:       run_frame("rnd_short", 8'($urandom_range(255, 0)), 0, 0, 0,
                                   int'($urandom_range(10, 0)), int'($urandom_range(12, 4)), -1);
                default: run_frame("rnd_ok", 8'($urandom_range(255, 0)), 0, 0, 0, -1, 0,
                                   int'($urandom_range(12, 0)));
            endcase
        end

        // Known-good code before the reset test so a held value would show up.
        run_frame("pre_rst", 8'hA7, 0, 0, 0, -1, 0, -1);
        fb = make_frame(8'h77, 0, 0, 0);
        send_frame(fb, 4, -1, 0, -1, rc);
        idle(5);
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check_eq("arst_data", int'(bus.data), 0);
        check_eq("arst_ready", int'(bus.dataReady), 0);
        check_eq("arst_error", int'(bus.error), 0);
        last_good = 8'h00;
        idle(2);
        resetN = 1'b1;
        idle(30);
        run_frame("post_rst", 8'h5A, 0, 0, 0, -1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #5000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
